// File: rtl/spi_fsm_pkg.sv
// spi_fsm_pkg: shared types for the SPI burst sequencer.
//   spi_state_t  - sequencer state encoding
//   spi_strobe_t - bundle of the one-cycle memory-side strobes
//   cnt_width()  - width of the SCLK edge counter for a given word geometry
package spi_fsm_pkg;

    typedef enum logic [2:0] {
        ST_GET,
        ST_GOT,
        ST_RD_WAIT,
        ST_RD_LOAD,
        ST_RD_SHIFT,
        ST_WR_SHIFT,
        ST_WR_COMMIT,
        ST_DONE
    } spi_state_t;

    typedef struct packed {
        logic addr_we;
        logic addr_inc;
        logic sr_we;
        logic dm_we;
    } spi_strobe_t;

    // Enough bits to hold the longer of the two word lengths inclusive.
    function automatic int unsigned cnt_width(input int unsigned cmd_bits,
                                              input int unsigned data_bits);
        int unsigned m;
        m = (cmd_bits > data_bits) ? cmd_bits : data_bits;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: counts synchronised SCLK rising edges within a word.
// Ports:
//   clk, rst_n   - system clock, async active-low reset
//   i_cs         - chip select (high = deselected), forces count to 0
//   i_inc        - one-clk pulse per SCLK rising edge
//   i_clr        - restart the count; an edge in the same cycle counts as 1
//   i_hold       - keep the count at 0, ignoring edges
//   o_cnt        - current edge count
module spi_bit_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_cs,
    input  logic         i_inc,
    input  logic         i_clr,
    input  logic         i_hold,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_cs || i_hold) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= W'(i_inc);
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/spi_burst_fsm.sv
// spi_burst_fsm: SPI slave transaction sequencer. Decodes a command word
// (address + rw bit) and then sequences single or burst data words against
// a memory, emitting one-cycle strobes for the address latch, shift-register
// load and memory write.
// Parameters: CMD_BITS (edges per command word), DATA_BITS (edges per data
//   word), READ_LAT (clk cycles from addr_we/addr_inc to sr_we).
// Ports:
//   clk, rst_n - system clock, async active-low reset
//   cs         - chip select, high = deselected
//   sclk_pos   - one-clk pulse per synchronised SCLK rising edge
//   rw         - command rw bit (1 = read), sampled in GOT
//   addr_we, addr_inc, sr_we, dm_we - one-cycle strobes (mutually exclusive)
//   miso_en    - drive MISO while shifting read data
//   frame_err  - one-cycle pulse when cs rises mid-word
// Build option: define SPI_BURST_EN to keep transferring consecutive
//   addresses until cs rises; otherwise one data word per transaction.
import spi_fsm_pkg::*;

module spi_burst_fsm #(
    parameter int unsigned CMD_BITS  = 8,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned READ_LAT  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs,
    input  logic sclk_pos,
    input  logic rw,
    output logic addr_we,
    output logic addr_inc,
    output logic sr_we,
    output logic dm_we,
    output logic miso_en,
    output logic frame_err
);

    localparam int unsigned CW = cnt_width(CMD_BITS, DATA_BITS);
    localparam int unsigned WW = 4;
    localparam logic [CW-1:0] CMD_END  = CW'(CMD_BITS);
    localparam logic [CW-1:0] DATA_END = CW'(DATA_BITS);

    spi_state_t    r_state, w_next;
    logic [WW-1:0] r_wait, w_wait_nxt;
    logic [CW-1:0] w_cnt;
    logic          w_clr, w_hold;
    spi_strobe_t   r_stb, w_stb;
    logic          r_miso, w_miso;
    logic          r_ferr, w_ferr;

    spi_bit_counter #(
        .W (CW)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_cs   (cs),
        .i_inc  (sclk_pos),
        .i_clr  (w_clr),
        .i_hold (w_hold),
        .o_cnt  (w_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_GET;
            r_wait  <= '0;
            r_stb   <= '0;
            r_miso  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_nxt;
            r_stb   <= w_stb;
            r_miso  <= w_miso;
            r_ferr  <= w_ferr;
        end
    end

    // Outputs are registered from the next state, so each strobe is high
    // during the cycle its state is current (addr_we marks the GOT cycle).
    always_comb begin
        w_next     = r_state;
        w_wait_nxt = r_wait;
        w_clr      = 1'b0;
        w_ferr     = 1'b0;

        if (cs) begin
            w_next = ST_GET;
            w_ferr = (w_cnt != '0) ||
                     (r_state inside {ST_GOT, ST_RD_WAIT, ST_RD_LOAD, ST_WR_COMMIT});
        end else begin
            case (r_state)
                ST_GET: begin
                    if (w_cnt == CMD_END) w_next = ST_GOT;
                end
                ST_GOT: begin
                    w_clr = 1'b1;
                    if (rw) begin
                        if (READ_LAT == 1) begin
                            w_next = ST_RD_LOAD;
                        end else begin
                            w_next     = ST_RD_WAIT;
                            w_wait_nxt = WW'(READ_LAT - 1);
                        end
                    end else begin
                        w_next = ST_WR_SHIFT;
                    end
                end
                // r_wait holds the RD_WAIT cycles still to spend, this one included.
                ST_RD_WAIT: begin
                    if (r_wait == WW'(1)) w_next = ST_RD_LOAD;
                    else                  w_wait_nxt = r_wait - 1'b1;
                end
                ST_RD_LOAD: begin
                    w_next = ST_RD_SHIFT;
                end
                ST_RD_SHIFT: begin
                    if (w_cnt == DATA_END) begin
                        w_clr = 1'b1;
`ifdef SPI_BURST_EN
                        // The addr_inc cycle is the first RD_WAIT cycle, so the
                        // full READ_LAT is spent waiting here.
                        w_next     = ST_RD_WAIT;
                        w_wait_nxt = WW'(READ_LAT);
`else
                        w_next = ST_DONE;
`endif
                    end
                end
                ST_WR_SHIFT: begin
                    if (w_cnt == DATA_END) begin
                        w_clr  = 1'b1;
                        w_next = ST_WR_COMMIT;
                    end
                end
                ST_WR_COMMIT: begin
`ifdef SPI_BURST_EN
                    w_next = ST_WR_SHIFT;
`else
                    w_next = ST_DONE;
`endif
                end
                ST_DONE: begin
                    w_next = ST_DONE;
                end
                default: begin
                    w_next = ST_GET;
                end
            endcase
        end

        // Zeroing on entry as well as in DONE keeps a stray edge on the final
        // word-end cycle from leaving a non-zero count behind.
        w_hold = (w_next == ST_DONE);

        w_stb         = '0;
        w_stb.addr_we = (w_next == ST_GOT);
        w_stb.sr_we   = (w_next == ST_RD_LOAD);
        w_stb.dm_we   = (w_next == ST_WR_COMMIT);
`ifdef SPI_BURST_EN
        w_stb.addr_inc = ((r_state == ST_RD_SHIFT)  && (w_next == ST_RD_WAIT)) ||
                         ((r_state == ST_WR_COMMIT) && (w_next == ST_WR_SHIFT));
`endif
        w_miso = (w_next == ST_RD_SHIFT);
    end

    assign addr_we   = r_stb.addr_we;
    assign addr_inc  = r_stb.addr_inc;
    assign sr_we     = r_stb.sr_we;
    assign dm_we     = r_stb.dm_we;
    assign miso_en   = r_miso;
    assign frame_err = r_ferr;

endmodule

// File: doc/spi_burst_fsm.md
SPI_BURST_FSM -- requirements
Module: spi_burst_fsm

Interface
REQ-001 Parameter CMD_BITS, default 8, SCLK rising edges per command word (address plus rw bit), range 2..16.
REQ-002 Parameter DATA_BITS, default 8, SCLK rising edges per data word, range 2..32.
REQ-003 Parameter READ_LAT, default 2, clk cycles from addr_we (or addr_inc) to sr_we, range 1..8.
REQ-004 clk  input  1  system clock; all state changes on posedge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 cs  input  1  chip select, high = deselected.
REQ-007 sclk_pos  input  1  one-clk pulse per synchronised SCLK rising edge.
REQ-008 rw  input  1  command rw bit, sampled in GOT; 1 = read, 0 = write.
REQ-009 addr_we  output  1  one-cycle strobe: latch address from shift register.
REQ-010 addr_inc  output  1  one-cycle strobe: increment address latch (burst only).
REQ-011 sr_we  output  1  one-cycle strobe: parallel-load shift register from memory.
REQ-012 dm_we  output  1  one-cycle strobe: write shift register to memory.
REQ-013 miso_en  output  1  level: drive MISO.
REQ-014 frame_err  output  1  one-cycle pulse: transaction aborted mid-word.

Function
REQ-015 All outputs registered; bit counter cnt, width $clog2(max(CMD_BITS,DATA_BITS))+1, increments by sclk_pos while cs low.
REQ-016 States: GET, GOT, RD_WAIT, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT, DONE.
REQ-017 GET: miso_en=0; cnt==CMD_BITS -> GOT.
REQ-018 GOT (one cycle): addr_we=1; cnt<=sclk_pos (clear, same-cycle edge not lost); rw=1 -> RD_WAIT, else WR_SHIFT.
REQ-019 RD_WAIT: stay READ_LAT-1 cycles (zero when READ_LAT=1), then RD_LOAD.
REQ-020 RD_LOAD (one cycle): sr_we=1 -> RD_SHIFT.
REQ-021 RD_SHIFT: miso_en=1; cnt==DATA_BITS -> cnt cleared per REQ-018 rule, then burst target (REQ-030) or DONE.
REQ-022 WR_SHIFT: cnt==DATA_BITS -> WR_COMMIT, cnt cleared per REQ-018 rule.
REQ-023 WR_COMMIT (one cycle): dm_we=1 -> burst target (REQ-030) or DONE.
REQ-024 DONE: cnt held 0, strobes 0, miso_en 0; remain until cs high.
REQ-025 cs high, any state: next cycle state=GET, cnt=0, all strobes 0, miso_en=0; cs has priority over every transition.
REQ-026 frame_err=1 for exactly the first cycle cs is seen high while cnt!=0 or state in {GOT, RD_WAIT, RD_LOAD, WR_COMMIT}; never otherwise.
REQ-027 At most one of addr_we, addr_inc, sr_we, dm_we is 1 in any cycle.
REQ-028 System constraint: READ_LAT+2 clk cycles shorter than one SCLK half-period; no edge lost in RD_WAIT/RD_LOAD (counted normally).

Reset
REQ-029 rst_n low: state=GET, cnt=0, all outputs 0 immediately; first transition on first posedge after rst_n high.

Configuration
REQ-030 Macro SPI_BURST_EN defined: after RD_SHIFT word end, addr_inc=1 one cycle and go RD_WAIT (READ_LAT counted from addr_inc); after WR_COMMIT, addr_inc=1 next cycle and go WR_SHIFT; burst ends only by cs high. Undefined: both go DONE, addr_inc tied 0.

Structure
REQ-031 Package spi_fsm_pkg SHALL hold state enum and strobe-bundle typedef; shared by bench.
REQ-032 Sub-module spi_bit_counter SHALL implement cnt (increment, clear-with-load, cs reset); FSM instantiates one.

Verification
REQ-033 Write, defaults: cs low, 8 edges rw=0, 8 edges -> addr_we one cycle after 8th edge, dm_we one cycle after 16th, then DONE, no frame_err.
REQ-034 Read, READ_LAT=3: 8 edges rw=1 -> addr_we at T, sr_we at T+3, miso_en from T+4 until cs high or word end.
REQ-035 Burst (SPI_BURST_EN): read command + 24 data edges -> three sr_we, two addr_inc each READ_LAT before following sr_we; without macro one sr_we, DONE.
REQ-036 Abort: cs high after 5 command edges -> frame_err one cycle, GET, cnt 0; cs high in DONE -> no frame_err.
REQ-037 Edge in GOT cycle: sclk_pos coincident with addr_we -> cnt=1 afterwards; write completes after 7 further edges.
REQ-038 rst_n low mid-RD_SHIFT -> outputs 0 without clk; clean write transaction succeeds after release.
